// File: rtl/neuron_preact_accum.sv
// Reservoir neuron pre-activation: bias + sum of N_TERMS (w*x)>>>15 terms, saturated to Q2.15.
// Optional sat_flag output enabled by defining NEURON_ACCUM_SAT_FLAG_EN.
module neuron_preact_accum #(
    parameter int N_TERMS = 8,
    parameter int ACC_W   = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] bias,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_w,
    input  logic [15:0] in_x,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [16:0] out_sum,
    output logic        busy
`ifdef NEURON_ACCUM_SAT_FLAG_EN
    ,
    output logic        sat_flag
`endif
);
    localparam int CNT_W = $clog2(N_TERMS + 1);
    localparam logic signed [ACC_W-1:0] POS_MAX = ACC_W'(65535);
    localparam logic signed [ACC_W-1:0] NEG_MIN = ACC_W'(-65536);

    typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [16:0]             sum_q;

    logic signed [15:0]      w_s, x_s;
    logic signed [31:0]      prod;
    logic signed [ACC_W-1:0] term, acc_nxt;
    logic [16:0]             sat_val;
    logic                    accept, last;

    assign w_s     = in_w;
    assign x_s     = in_x;
    assign prod    = 32'(w_s) * 32'(x_s);
    // Arithmetic shift floors toward -inf; the 17-bit result always fits ACC_W.
    assign term    = ACC_W'(prod >>> 15);
    assign acc_nxt = acc_q + term;

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == OUT);
    assign busy      = (state_q != IDLE);
    assign out_sum   = sum_q;
    assign accept    = in_valid && in_ready;
    assign last      = (cnt_q == CNT_W'(N_TERMS - 1));

    always_comb begin
        sat_val = acc_nxt[16:0];
        if (acc_nxt > POS_MAX)
            sat_val = 17'h0FFFF;
        else if (acc_nxt < NEG_MIN)
            sat_val = 17'h10000;
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = ACC_W'($signed(bias));
                    cnt_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d = acc_nxt;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last)
                        state_d = OUT;
                end
            end
            OUT: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef NEURON_ACCUM_SAT_FLAG_EN
    logic sat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
            sat_q <= 1'b0;
        end else if (accept && last) begin
            sum_q <= sat_val;
            sat_q <= (acc_nxt > POS_MAX) || (acc_nxt < NEG_MIN);
        end
    end

    assign sat_flag = sat_q;
`else
    always_ff @(posedge clk) begin
        if (rst)
            sum_q <= '0;
        else if (accept && last)
            sum_q <= sat_val;
    end
`endif

endmodule

// File: tb/tb_neuron_preact_accum.sv
// Directed bench for neuron_preact_accum: table of frames plus handshake/reset sequences.
module tb_neuron_preact_accum;
    logic        clk = 1'b0;
    logic        rst, start, in_valid, out_ready;
    logic [15:0] bias, in_w, in_x;
    logic        in_ready, out_valid, busy;
    logic [16:0] out_sum;
`ifdef NEURON_ACCUM_SAT_FLAG_EN
    logic        sat_flag;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    neuron_preact_accum #(.N_TERMS(8), .ACC_W(24)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bias      (bias),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_w      (in_w),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .busy      (busy)
`ifdef NEURON_ACCUM_SAT_FLAG_EN
        ,
        .sat_flag  (sat_flag)
`endif
    );

    typedef struct {
        logic [15:0] bias;
        logic [15:0] w;
        logic [15:0] x;
        logic [16:0] exp_sum;
        logic        exp_sat;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic run_frame(input vec_t v, input bit rand_v, input int hold);
        int          n_acc;
        int          cyc;
        logic [16:0] held;
        out_ready = (hold == 0);
        start     = 1'b1;
        bias      = v.bias;
        @(posedge clk); #1;
        start = 1'b0;
        bias  = 16'h5A5A;
        check("busy_in_accum", busy, 1);
        n_acc = 0;
        cyc   = 0;
        while (n_acc < 8 && cyc < 100) begin
            in_valid = rand_v ? 1'($urandom_range(0, 1)) : 1'b1;
            in_w     = v.w;
            in_x     = v.x;
            check("accum_in_ready", in_ready, 1);
            check("accum_no_valid", out_valid, 0);
            @(posedge clk);
            if (in_valid) n_acc++;
            cyc++;
            #1;
        end
        check("accept_count", n_acc, 8);
        // Stray traffic while OUT must not disturb the result.
        in_valid = 1'b1;
        check("out_valid_rise", out_valid, 1);
        check("out_in_ready_low", in_ready, 0);
        check("out_sum", out_sum, v.exp_sum);
`ifdef NEURON_ACCUM_SAT_FLAG_EN
        check("sat_flag", sat_flag, v.exp_sat);
`endif
        held = out_sum;
        for (int i = 0; i < hold; i++) begin
            start = (i == 2);
            @(posedge clk); #1;
            check("hold_valid", out_valid, 1);
            check("hold_sum", out_sum, held);
            check("hold_busy", busy, 1);
        end
        // Handshake with a coincident start: start must be dropped.
        out_ready = 1'b1;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("idle_after_hs", busy, 0);
        check("valid_drop", out_valid, 0);
        @(posedge clk); #1;
        check("stay_idle", busy, 0);
    endtask

    initial begin
        vecs[0] = '{16'h0000, 16'h4000, 16'h2000, 17'h08000, 1'b0};
        vecs[1] = '{16'h1000, 16'h4000, 16'h4000, 17'h0FFFF, 1'b1};
        vecs[2] = '{16'h0000, 16'h8000, 16'h7FFF, 17'h10000, 1'b1};
        vecs[3] = '{16'h0000, 16'hFFFF, 16'h0001, 17'h1FFF8, 1'b0};
        vecs[4] = '{16'h7FFF, 16'h4000, 16'h2000, 17'h0FFFF, 1'b0};
        vecs[5] = '{16'h8000, 16'hC000, 16'h2000, 17'h10000, 1'b0};

        rst = 1'b1; start = 1'b0; bias = '0; in_valid = 1'b0;
        in_w = '0; in_x = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
`ifdef NEURON_ACCUM_SAT_FLAG_EN
        check("rst_sat_flag", sat_flag, 0);
`endif
        rst = 1'b0;

        // Terms offered in IDLE are not accepted.
        in_valid = 1'b1; in_w = 16'h4000; in_x = 16'h4000;
        repeat (3) begin
            @(posedge clk); #1;
            check("idle_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;

        for (int i = 0; i < 6; i++)
            run_frame(vecs[i], 1'b0, 0);

        run_frame(vecs[0], 1'b1, 5);
        run_frame(vecs[2], 1'b1, 5);

        // Reset mid-frame after four accepted terms.
        start = 1'b1; bias = 16'h0100;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; in_w = 16'h4000; in_x = 16'h4000;
        repeat (4) @(posedge clk);
        #1;
        check("mid_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_sum", out_sum, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        check("post_rst_idle", busy, 0);
        check("post_rst_no_valid", out_valid, 0);
        in_valid = 1'b0;
        run_frame(vecs[0], 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/neuron_preact_accum.md
NEURON_PREACT_ACCUM -- requirements
Module: neuron_preact_accum

Interface
REQ-001 SHALL have parameter N_TERMS, default 8: weighted terms per frame, range 2..256.
REQ-002 SHALL have parameter ACC_W, default 24: internal accumulator width, at least 18+clog2(N_TERMS).
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1: frame-start pulse, honoured only in IDLE.
REQ-006 SHALL have port bias, input, 16: signed Q1.15 bias, sampled on an accepted start.
REQ-007 SHALL have port in_valid, input, 1: a term is present on in_w/in_x.
REQ-008 SHALL have port in_ready, output, 1: block accepts a term this cycle.
REQ-009 SHALL have port in_w, input, 16: signed Q1.15 weight.
REQ-010 SHALL have port in_x, input, 16: signed Q1.15 reservoir state.
REQ-011 SHALL have port out_valid, output, 1: out_sum holds a result.
REQ-012 SHALL have port out_ready, input, 1: downstream activation stage accepts the result.
REQ-013 SHALL have port out_sum, output, 17: signed Q2.15 saturated pre-activation for the 17-bit activation input.
REQ-014 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, ACCUM, OUT.
REQ-016 In IDLE, start=1 SHALL load acc with sign-extended bias, clear the term counter, and move to ACCUM.
REQ-017 In ACCUM, in_ready SHALL be 1, and in_ready SHALL be 0 in all other states.
REQ-018 A term SHALL be accepted when in_valid and in_ready are both 1 in the same cycle.
REQ-019 On each accepted term, acc SHALL add (in_w*in_x)>>>15, where the 32-bit signed product is shifted arithmetically, truncating toward negative infinity.
REQ-020 The term counter SHALL increment on each accepted term, and acceptance of term N_TERMS SHALL move the FSM to OUT.
REQ-021 On entering OUT, out_sum SHALL register sat(acc) including the final term, and out_valid SHALL rise on the cycle after the last term is accepted.
REQ-022 sat() SHALL map acc>65535 to 17'h0FFFF, acc<-65536 to 17'h10000, and otherwise pass acc[16:0].
REQ-023 In OUT, out_valid and out_sum SHALL hold stable until out_ready=1, after which the FSM SHALL return to IDLE on the next edge.
REQ-024 start SHALL be ignored in ACCUM and OUT, and a start in the same cycle as the OUT-to-IDLE handshake SHALL be ignored.
REQ-025 in_valid with in_ready=0 SHALL NOT change acc or the counter.
REQ-026 The accumulator SHALL NOT saturate internally, because ACC_W guarantees no wrap.

Reset
REQ-027 rst=1 SHALL force IDLE, acc=0, counter=0, out_sum=0, out_valid=0, in_ready=0, and busy=0 at the next edge.
REQ-028 rst SHALL take priority over start and over every handshake, and reset mid-frame SHALL discard the partial sum without producing output.

Configuration
REQ-029 With macro NEURON_ACCUM_SAT_FLAG_EN defined, the block SHALL add output port sat_flag (1 bit), registered with out_sum, which is 1 exactly when sat() clipped, held while out_valid=1, and cleared to 0 by reset.
REQ-030 Without NEURON_ACCUM_SAT_FLAG_EN, the block SHALL have no sat_flag port, and all other behaviour SHALL be identical.

Verification
REQ-031 Bench SHALL cover: bias=0, 8 terms w=16'h4000, x=16'h2000, out_ready=1 -> out_sum=17'h08000, and out_valid rises 1 cycle after the 8th accept.
REQ-032 Bench SHALL cover: bias=16'h1000, 8 terms w=x=16'h4000 -> out_sum=17'h0FFFF, and sat_flag=1 when the macro is enabled.
REQ-033 Bench SHALL cover: bias=0, 8 terms w=16'h8000, x=16'h7FFF -> out_sum=17'h10000 (negative clip).
REQ-034 Bench SHALL cover: bias=0, 8 terms w=16'hFFFF, x=16'h0001 -> out_sum=17'h1FFF8 (truncation -1 per term).
REQ-035 Bench SHALL cover: in_valid toggling randomly plus out_ready low for 5 cycles -> same out_sum, out_valid held for 5 cycles, and a start during OUT is ignored.
REQ-036 Bench SHALL cover: rst=1 after 4 accepted terms -> all outputs 0 next cycle, then a fresh frame yields the correct sum.
